// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one SRAM-like bus between instruction fetch (I)
// and the memory stage (D). One transaction in flight at a time, D has fixed
// priority, and a cancelled fetch is drained from the bus but never reported.
module sram_bus_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  // fetch side
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  input  logic          i_cancel,
  output logic [DW-1:0] i_rdata,
  output logic          i_data_ok,
  output logic          i_stall,
  // memory-stage side
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [1:0]    d_size,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_data_ok,
  output logic          d_stall,
  // bus side
  output logic          bus_req,
  output logic          bus_wr,
  output logic [1:0]    bus_size,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_addr_ok,
  input  logic          bus_data_ok,
  input  logic [DW-1:0] bus_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [1:0] state;
  logic [1:0] state_next;
  logic       grant_d;    // 1: transaction belongs to D, 0: belongs to I
  logic       discard;    // in-flight fetch was cancelled; drop its data
  logic       complete;   // the bus transaction finishes this cycle
  logic       start_d;
  logic       start_i;

  // Arbitration decision, only meaningful while IDLE; D always wins.
  always_comb begin
    start_d = 1'b0;
    start_i = 1'b0;
    if (state == IDLE) begin
      start_d = d_req;
      start_i = ~d_req & i_req & ~i_cancel;
    end else begin
      start_d = 1'b0;
      start_i = 1'b0;
    end
  end

  // Completion: data returns either together with acceptance or later in WAIT.
  always_comb begin
    complete = 1'b0;
    case (state)
      REQ:     complete = bus_addr_ok & bus_data_ok;
      WAIT:    complete = bus_data_ok;
      default: complete = 1'b0;
    endcase
  end

  // Completion pulses and gated read data go straight out, no extra stage,
  // so a cancel arriving with the data still suppresses the fetch pulse.
  always_comb begin
    d_data_ok = complete & grant_d;
    i_data_ok = complete & ~grant_d & ~discard & ~i_cancel;
    d_rdata   = d_data_ok ? bus_rdata : {DW{1'b0}};
    i_rdata   = i_data_ok ? bus_rdata : {DW{1'b0}};
    d_stall   = d_req & ~d_data_ok;
    i_stall   = i_req & ~i_data_ok;
  end

  // The bus request is a pure state decode; it is never withdrawn early.
  always_comb begin
    bus_req = (state == REQ);
  end

  // Next-state logic for the IDLE -> REQ -> (WAIT) -> IDLE sequence.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_d | start_i) begin
          state_next = REQ;
        end else begin
          state_next = IDLE;
        end
      end
      REQ: begin
        if (bus_addr_ok) begin
          state_next = bus_data_ok ? IDLE : WAIT;
        end else begin
          state_next = REQ;
        end
      end
      WAIT: begin
        if (bus_data_ok) begin
          state_next = IDLE;
        end else begin
          state_next = WAIT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Grant and bus payload are captured once at issue and held until the next issue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_d   <= 1'b0;
      bus_wr    <= 1'b0;
      bus_size  <= 2'd0;
      bus_addr  <= {AW{1'b0}};
      bus_wdata <= {DW{1'b0}};
    end else if (start_d) begin
      grant_d   <= 1'b1;
      bus_wr    <= d_wr;
      bus_size  <= d_size;
      bus_addr  <= d_addr;
      bus_wdata <= d_wdata;
    end else if (start_i) begin
      grant_d   <= 1'b0;
      bus_wr    <= 1'b0;
      bus_size  <= 2'd2;
      bus_addr  <= i_addr;
      bus_wdata <= {DW{1'b0}};
    end
  end

  // Discard flag: a fetch cancelled while on the bus must still drain, silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      discard <= 1'b0;
    end else if (complete) begin
      discard <= 1'b0;
    end else if (i_cancel & ~grant_d & (state != IDLE)) begin
      discard <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Randomized scoreboard bench for sram_bus_arbiter. Requesters push expected
// transactions into per-port queues; a bus slave model serves the bus; a
// negedge monitor pops and compares whenever a data_ok pulse appears.
module tb_sram_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, i_cancel;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_data_ok, i_stall;
  logic          d_req, d_wr;
  logic [1:0]    d_size;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_data_ok, d_stall;
  logic          bus_req, bus_wr;
  logic [1:0]    bus_size;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_addr_ok, bus_data_ok;
  logic [DW-1:0] bus_rdata;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] wdata;
  } txn_t;

  txn_t d_q[$];
  txn_t i_q[$];
  txn_t acc;              // payload the slave accepted for the current transaction
  int   checks = 0;
  int   errors = 0;
  bit   d_done = 1'b0, i_done = 1'b0;
  bit   issue_en = 1'b0, slave_long = 1'b0, slave_busy = 1'b0;

  sram_bus_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_cancel(i_cancel),
    .i_rdata(i_rdata), .i_data_ok(i_data_ok), .i_stall(i_stall),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_data_ok(d_data_ok), .d_stall(d_stall),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  // Memory contents as seen by the slave: a fixed scramble of the address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic new_d();
    d_wr    = 1'($urandom_range(0, 1));
    d_size  = 2'($urandom_range(0, 2));
    d_addr  = $urandom;
    d_wdata = $urandom;
    d_req   = 1'b1;
    d_q.push_back('{addr: d_addr, wr: d_wr, size: d_size, wdata: d_wdata});
  endtask

  task automatic new_i(input logic [31:0] a);
    i_addr = a;
    i_req  = 1'b1;
    i_q.push_back('{addr: a, wr: 1'b0, size: 2'd2, wdata: 32'd0});
  endtask

  // One cycle of requester behaviour, called just after each rising edge.
  task automatic drive_cycle();
    i_cancel = 1'b0;
    if (d_req) begin
      if (d_done) begin
        d_done = 1'b0;
        d_req  = 1'b0;
        d_addr = $urandom;
        if (issue_en && $urandom_range(0, 1) == 1) new_d();
      end
    end else if (issue_en && $urandom_range(0, 3) == 0) begin
      new_d();
    end
    if (i_req) begin
      if (i_done) begin
        i_done = 1'b0;
        i_req  = 1'b0;
        if (issue_en && $urandom_range(0, 1) == 1) new_i($urandom & 32'hFFFF_FFFC);
      end else if (issue_en && $urandom_range(0, 11) == 0) begin
        i_req    = 1'b0;
        i_cancel = 1'b1;
        void'(i_q.pop_front());
      end
    end else if (issue_en && $urandom_range(0, 2) == 0) begin
      new_i($urandom & 32'hFFFF_FFFC);
    end
  endtask

  // Bus slave model: random refusals, random wait states, optional combined
  // accept+data, and occasional stray data_ok while the bus is idle.
  initial begin
    logic req_seen;
    int   delay;
    int   refuse;
    delay = 0;
    refuse = -1;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata = 32'd0;
    forever begin
      @(negedge clk);
      req_seen = bus_req;
      @(posedge clk);
      #1;
      if (reset) begin
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = 32'd0;
        slave_busy  = 1'b0;
        refuse      = -1;
      end else begin
        if (bus_data_ok) slave_busy = 1'b0;
        else if (bus_addr_ok && req_seen) slave_busy = 1'b1;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = 32'd0;
        if (slave_busy) begin
          chk("no_overlap", {95'd0, bus_req}, 96'd0);
          if (delay == 0) begin
            bus_data_ok = 1'b1;
            bus_rdata   = mem_fn(acc.addr);
          end else begin
            delay--;
          end
        end else if (bus_req) begin
          if (refuse < 0) refuse = ($urandom_range(0, 5) == 0) ? 5 : int'($urandom_range(0, 1));
          if (refuse > 0) begin
            refuse--;
          end else begin
            refuse = -1;
            bus_addr_ok = 1'b1;
            acc = '{addr: bus_addr, wr: bus_wr, size: bus_size, wdata: bus_wdata};
            if (!slave_long && $urandom_range(0, 2) == 0) begin
              bus_data_ok = 1'b1;
              bus_rdata   = mem_fn(bus_addr);
            end else begin
              delay = slave_long ? 40 : int'($urandom_range(0, 3));
            end
          end
        end else begin
          refuse = -1;
          if ($urandom_range(0, 15) == 0) begin
            bus_data_ok = 1'b1;
            bus_rdata   = $urandom;
          end
        end
      end
    end
  end

  // Monitor: per-cycle output rules, arbitration order, payload stability, scoreboard pops.
  initial begin
    logic pb, pd, pi, pc;
    txn_t pdt, pbt, cur, t;
    logic [31:0] pia;
    pb = 1'b0; pd = 1'b0; pi = 1'b0; pc = 1'b0; pia = 32'd0;
    pdt = '0; pbt = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pb = 1'b0; pd = 1'b0; pi = 1'b0; pc = 1'b0;
      end else begin
        cur = '{addr: bus_addr, wr: bus_wr, size: bus_size, wdata: bus_wdata};
        chk("i_stall", {95'd0, i_stall}, {95'd0, i_req & ~i_data_ok});
        chk("d_stall", {95'd0, d_stall}, {95'd0, d_req & ~d_data_ok});
        if (!i_data_ok) chk("i_rdata_idle", {64'd0, i_rdata}, 96'd0);
        if (!d_data_ok) chk("d_rdata_idle", {64'd0, d_rdata}, 96'd0);
        if (bus_req && !pb) begin
          if (pd) chk("grant_d_payload", cur, pdt);
          else if (pi && !pc) chk("grant_i_payload", {bus_addr, bus_wr, bus_size}, {pia, 1'b0, 2'd2});
          else chk("spurious_issue", 96'd1, 96'd0);
        end
        if (bus_req && pb) chk("payload_stable", cur, pbt);
        if (d_data_ok) begin
          if (d_q.size() == 0) begin
            chk("d_stray_ok", 96'd1, 96'd0);
          end else begin
            t = d_q.pop_front();
            chk("d_rdata", {64'd0, d_rdata}, {64'd0, mem_fn(t.addr)});
            chk("d_bus_payload", acc, t);
            d_done = 1'b1;
          end
        end
        if (i_data_ok) begin
          if (i_q.size() == 0) begin
            chk("i_stray_ok", 96'd1, 96'd0);
          end else begin
            t = i_q.pop_front();
            chk("i_rdata", {64'd0, i_rdata}, {64'd0, mem_fn(t.addr)});
            chk("i_bus_payload", {acc.addr, acc.wr, acc.size}, {t.addr, 1'b0, 2'd2});
            i_done = 1'b1;
          end
        end
        pb = bus_req; pbt = cur;
        pd = d_req; pdt = '{addr: d_addr, wr: d_wr, size: d_size, wdata: d_wdata};
        pi = i_req; pc = i_cancel; pia = i_addr;
      end
    end
  end

  // Main sequence: reset values, reset mid-WAIT, directed conflict, random run, drain.
  initial begin
    int n;
    reset = 1'b1;
    i_req = 1'b0; i_cancel = 1'b0; i_addr = 32'd0;
    d_req = 1'b0; d_wr = 1'b0; d_size = 2'd0; d_addr = 32'd0; d_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bus_req", {95'd0, bus_req}, 96'd0);
    chk("rst_payload", {bus_addr, bus_wr, bus_size, bus_wdata}, 96'd0);
    chk("rst_data_ok", {94'd0, i_data_ok, d_data_ok}, 96'd0);
    chk("rst_rdata", {i_rdata, d_rdata}, 96'd0);
    @(negedge clk);
    reset = 1'b0;

    // Fetch parked in WAIT behind a slow slave, then reset hits.
    slave_long = 1'b1;
    @(posedge clk);
    #1;
    new_i(32'hBFC0_0000);
    n = 0;
    while (!slave_busy && n < 30) begin
      @(posedge clk);
      #3;
      n++;
    end
    chk("reached_wait", {95'd0, slave_busy}, 96'd1);
    reset = 1'b1;
    #1;
    chk("midrst_bus_req", {95'd0, bus_req}, 96'd0);
    chk("midrst_data_ok", {94'd0, i_data_ok, d_data_ok}, 96'd0);
    chk("midrst_addr", {64'd0, bus_addr}, 96'd0);
    i_req = 1'b0;
    i_q.delete();
    d_q.delete();
    i_done = 1'b0;
    d_done = 1'b0;
    slave_long = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Conflict: fetch and store raised together; D must go first.
    @(posedge clk);
    #1;
    new_i(32'hBFC0_0380);
    d_wr = 1'b1; d_size = 2'd2; d_addr = 32'h8000_0100; d_wdata = 32'hDEAD_BEEF; d_req = 1'b1;
    d_q.push_back('{addr: d_addr, wr: 1'b1, size: 2'd2, wdata: d_wdata});
    n = 0;
    while ((d_req || i_req) && n < 100) begin
      @(posedge clk);
      #1;
      drive_cycle();
      n++;
    end
    chk("directed_drain", {94'd0, d_req, i_req}, 96'd0);

    // Random traffic.
    issue_en = 1'b1;
    repeat (3000) begin
      @(posedge clk);
      #1;
      drive_cycle();
    end
    issue_en = 1'b0;
    n = 0;
    while ((d_req || i_req) && n < 300) begin
      @(posedge clk);
      #1;
      drive_cycle();
      n++;
    end
    chk("final_drain", {94'd0, d_req, i_req}, 96'd0);
    chk("queues_empty", 96'(d_q.size() + i_q.size()), 96'd0);
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_bus_arbiter.md
# sram_bus_arbiter

Two-to-one arbiter and sequencer for the core's single SRAM-like memory bus. It shares the bus between the fetch stage (instruction reads) and the memory stage (data reads and writes), with one outstanding transaction at a time. It returns completion pulses and stall indications that the hazard unit folds into stallF and stallM. It sits between the pipeline's fetch and memory stages and the external bus / cache port.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- i_req  in  1  fetch requests a read; held until i_data_ok or i_cancel
- i_addr  in  AW  fetch address (pcF)
- i_cancel  in  1  one-cycle pulse; the current fetch request is abandoned (exception/branch redirect)
- i_rdata  out  DW  instruction word; valid only when i_data_ok=1
- i_data_ok  out  1  one-cycle fetch completion pulse
- i_stall  out  1  i_req & ~i_data_ok
- d_req  in  1  memory stage requests an access; held until d_data_ok
- d_wr  in  1  1=write, 0=read
- d_size  in  2  0=byte, 1=half, 2=word
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_rdata  out  DW  load data; valid only when d_data_ok=1
- d_data_ok  out  1  one-cycle data completion pulse
- d_stall  out  1  d_req & ~d_data_ok
- bus_req  out  1  bus request; held until bus_addr_ok
- bus_wr, bus_size, bus_addr, bus_wdata  out  1/2/AW/DW  latched payload
- bus_addr_ok  in  1  slave accepted the request
- bus_data_ok  in  1  slave completed the transaction
- bus_rdata  in  DW  read data, valid with bus_data_ok

## Operation
- States: IDLE, REQ, WAIT. Registers: state, grant (I/D), payload (wr, size, addr, wdata), discard.
- IDLE:
  - If d_req=1, grant=D, latch the d_* payload, and go to REQ.
  - Else if i_req=1 and i_cancel=0, grant=I, latch i_addr with wr=0 and size=2, and go to REQ.
  - D has fixed priority over I.
- REQ:
  - bus_req=1 with the latched payload.
  - bus_addr_ok=1 and bus_data_ok=0: go to WAIT.
  - bus_addr_ok=1 and bus_data_ok=1: complete and go to IDLE.
  - bus_addr_ok=0: stay in REQ. The request is never withdrawn, even if the transaction is cancelled.
- WAIT:
  - bus_req=0.
  - On bus_data_ok=1: complete and go to IDLE.
  - bus_data_ok is ignored in IDLE.
- Completion:
  - grant=D: d_data_ok=1 and d_rdata=bus_rdata.
  - grant=I with discard=0: i_data_ok=1 and i_rdata=bus_rdata.
  - grant=I with discard=1: no pulse is issued; the data is dropped and discard is cleared.
- i_cancel:
  - While grant=I in REQ or WAIT: set discard.
  - In IDLE, or while grant=D: no effect, since nothing for I is in flight.
  - A cancel in the same cycle as I's completion suppresses that i_data_ok.
- Payload outputs are registered. bus_req is a decode of state only.
- Outputs at reset: state=IDLE, bus_req=0, bus payload=0, discard=0, i_data_ok=0, d_data_ok=0. i_rdata and d_rdata are 0 whenever their data_ok=0.

## Timing
- Request sampled at edge t; bus_req=1 in cycle t+1.
- Minimum latency, requester request to data_ok:
  - 1 cycle when addr_ok and data_ok arrive together.
  - Otherwise 2 cycles plus slave wait states.
- The data_ok outputs are combinational from bus_data_ok, with no added register stage.
- After a completion in cycle c, the state is IDLE in c+1. The requester has dropped or changed its request by c+1, so the stale request is never re-granted. Back-to-back issue: bus_req again in c+2.
- A pending I waits behind any sequence of D requests. This is accepted because D is bounded by pipeline stalls.
- reset asserted mid-transaction: return to IDLE immediately and drop all state. The slave shares the same reset.
- bus_wdata, bus_addr, bus_size and bus_wr stay stable from REQ entry until return to IDLE.

## Test plan
- **Single fetch:** i_req=1, i_addr=0xBFC00000; slave gives addr_ok in the first REQ cycle and data_ok 2 cycles later with 0x3C080001. Required: exactly one i_data_ok pulse carrying i_rdata=0x3C080001; bus_req high for exactly 1 cycle.
- **Conflict:** i_req and d_req (write, size=2, addr 0x80000100, wdata 0xDEADBEEF) asserted in the same cycle. Required: D is issued first with bus_wr=1 and the correct payload; d_data_ok pulses; I is then issued on the second bus_req; no overlap between the two.
- **Cancel in WAIT:** I transaction outstanding; i_cancel pulses, then i_req is presented with a new address 0xBFC00380. Required: the first data_ok is swallowed with no i_data_ok; the second transaction uses 0xBFC00380 and returns i_data_ok.
- **Slow slave:** bus_addr_ok held low for 5 cycles. Required: bus_req stays high and the payload stays constant for 5 cycles; i_stall and d_stall stay high throughout.
- **Combined accept:** bus_addr_ok and bus_data_ok asserted in the same cycle on a byte load (d_size=0). Required: d_data_ok in that same cycle; state returns to IDLE.
- **Reset mid-WAIT:** reset asserted while in WAIT. Required: bus_req=0 and both data_ok=0 immediately; a fresh request after reset issues normally.
